// File: rtl/tdm_lane_deserializer.sv
// tdm_lane_deserializer
// Rebuilds a FACTOR-lane parallel word from a time-multiplexed stream of
// WIDTH-bit lane words (lane 0 first). Optional start-of-frame alignment,
// mid-frame idle timeout and a saturating framing-error counter guard
// against a dropped or extra beat silently rotating channels.
module tdm_lane_deserializer #(
   parameter int FACTOR   = 2,
   parameter int WIDTH    = 32,
   parameter int SOF_MODE = 0,
   parameter int TIMEOUT  = 0,
   parameter int CNT_BITS = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        in,
   input  logic                    in_valid,
   input  logic                    in_sof,
   output logic [FACTOR*WIDTH-1:0] out,
   output logic                    out_valid,
   output logic                    frame_err,
   output logic                    synced,
   output logic [CNT_BITS-1:0]     err_count
);

   localparam int IDX_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;
   localparam int GAP_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   // Shadow keeps lanes 0..FACTOR-2; one dummy entry when FACTOR is 1.
   localparam int SH_N  = (FACTOR > 1) ? FACTOR - 1 : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FACTOR - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic             SOF_ON   = (SOF_MODE != 0);

   typedef enum logic {
      UNSYNC = 1'b0,
      SYNCED = 1'b1
   } state_t;

   localparam state_t RST_STATE = (SOF_MODE != 0) ? UNSYNC : SYNCED;

   // Saturating increment: the error counter sticks at all-ones.
   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [GAP_W-1:0]   gap;
   logic [GAP_W-1:0]   gap_nxt;
   logic               accept;
   logic [IDX_W-1:0]   acc_lane;
   logic               complete;
   logic               store;
   logic               err_evt;
   logic [WIDTH-1:0]   shadow [SH_N];
   logic [FACTOR*WIDTH-1:0] frame;

   // Next-state decode: lane placement, alignment errors and idle timeout.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      gap_nxt   = gap;
      accept    = 1'b0;
      acc_lane  = idx;
      err_evt   = 1'b0;
      complete  = 1'b0;
      store     = 1'b0;

      if (in_valid) begin
         gap_nxt = '0;
         if (state == UNSYNC) begin
            // Words before the first marker are dropped without complaint.
            if (in_sof) begin
               state_nxt = SYNCED;
               accept    = 1'b1;
               acc_lane  = '0;
            end
         end else if (SOF_ON && in_sof && (idx != '0)) begin
            // Marker arrived early: drop the partial frame, restart at lane 0.
            err_evt  = 1'b1;
            accept   = 1'b1;
            acc_lane = '0;
         end else if (SOF_ON && !in_sof && (idx == '0)) begin
            // Lane 0 without its marker means alignment was lost.
            err_evt   = 1'b1;
            state_nxt = UNSYNC;
         end else begin
            accept = 1'b1;
         end
      end else if ((TIMEOUT > 0) && (idx != '0)) begin
         if (gap == GAP_LAST) begin
            err_evt = 1'b1;
            idx_nxt = '0;
            gap_nxt = '0;
            if (SOF_ON) begin
               state_nxt = UNSYNC;
            end
         end else begin
            gap_nxt = gap + 1'b1;
         end
      end

      complete = accept && (acc_lane == IDX_LAST);
      store    = accept && !complete;
      if (complete) begin
         idx_nxt = '0;
      end else if (store) begin
         idx_nxt = acc_lane + 1'b1;
      end
   end

   // Assemble the finished frame from the shadow lanes plus the last beat.
   always_comb begin
      frame = out;
      for (int k = 0; k < FACTOR - 1; k++) begin
         frame[k*WIDTH +: WIDTH] = shadow[k];
      end
      frame[(FACTOR-1)*WIDTH +: WIDTH] = in;
   end

   // Control state, registered frame output and error counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_STATE;
         idx       <= '0;
         gap       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         gap       <= gap_nxt;
         out_valid <= complete;
         if (complete) begin
            out <= frame;
         end
         if (err_evt) begin
            err_count <= sat_inc(err_count);
         end
      end
   end

   // Lane shadow storage; stale contents are always overwritten before use.
   always_ff @(posedge clk) begin
      for (int k = 0; k < SH_N; k++) begin
         if (store && (acc_lane == IDX_W'(k))) begin
            shadow[k] <= in;
         end
      end
   end

   assign frame_err = err_evt & ~rst;
   assign synced    = (state == SYNCED);

endmodule

// File: tb/tb_tdm_lane_deserializer.sv
// Bench for tdm_lane_deserializer: four differently configured instances share
// one input stream; a frame-level reference model predicts every output.
module tb_tdm_lane_deserializer;

   localparam int PF  [4] = '{2, 2, 3, 1};   // FACTOR
   localparam int PSM [4] = '{0, 1, 1, 1};   // SOF_MODE
   localparam int PTO [4] = '{0, 4, 3, 0};   // TIMEOUT
   localparam int PCB [4] = '{16, 2, 4, 8};  // CNT_BITS

   logic        clk;
   logic        rst;
   logic [31:0] din;
   logic        in_valid;
   logic        in_sof;

   logic [63:0] o0;
   logic [63:0] o1;
   logic [95:0] o2;
   logic [31:0] o3;
   logic        ov [4];
   logic        fe [4];
   logic        sy [4];
   logic [15:0] ec0;
   logic [1:0]  ec1;
   logic [3:0]  ec2;
   logic [7:0]  ec3;

   logic [127:0] dout [4];
   logic [15:0]  dec  [4];

   int passed = 0;
   int total  = 0;

   tdm_lane_deserializer #(.FACTOR(2), .WIDTH(32), .SOF_MODE(0), .TIMEOUT(0), .CNT_BITS(16)) u0 (
      .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_sof(in_sof),
      .out(o0), .out_valid(ov[0]), .frame_err(fe[0]), .synced(sy[0]), .err_count(ec0));
   tdm_lane_deserializer #(.FACTOR(2), .WIDTH(32), .SOF_MODE(1), .TIMEOUT(4), .CNT_BITS(2)) u1 (
      .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_sof(in_sof),
      .out(o1), .out_valid(ov[1]), .frame_err(fe[1]), .synced(sy[1]), .err_count(ec1));
   tdm_lane_deserializer #(.FACTOR(3), .WIDTH(32), .SOF_MODE(1), .TIMEOUT(3), .CNT_BITS(4)) u2 (
      .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_sof(in_sof),
      .out(o2), .out_valid(ov[2]), .frame_err(fe[2]), .synced(sy[2]), .err_count(ec2));
   tdm_lane_deserializer #(.FACTOR(1), .WIDTH(32), .SOF_MODE(1), .TIMEOUT(0), .CNT_BITS(8)) u3 (
      .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_sof(in_sof),
      .out(o3), .out_valid(ov[3]), .frame_err(fe[3]), .synced(sy[3]), .err_count(ec3));

   assign dout[0] = 128'(o0);
   assign dout[1] = 128'(o1);
   assign dout[2] = 128'(o2);
   assign dout[3] = 128'(o3);
   assign dec[0]  = ec0;
   assign dec[1]  = 16'(ec1);
   assign dec[2]  = 16'(ec2);
   assign dec[3]  = 16'(ec3);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: collected words of the partial frame, idle count,
   // last delivered frame, and the error tally.
   typedef struct packed {
      logic             sync;
      logic [7:0]       cnt;
      logic [7:0]       gap;
      logic [3:0][31:0] buff;
      logic [127:0]     out;
      logic             ov;
      logic [15:0]      ec;
   } mst_t;

   mst_t m [4];
   logic started = 1'b0;

   function automatic mst_t take(input int i, input mst_t s, input logic [31:0] d);
      mst_t n;
      n = s;
      n.buff[n.cnt[1:0]] = d;
      n.cnt = n.cnt + 8'd1;
      if (int'(n.cnt) == PF[i]) begin
         n.out = '0;
         for (int k = 0; k < PF[i]; k++) n.out[k*32 +: 32] = n.buff[k];
         n.ov  = 1'b1;
         n.cnt = '0;
      end
      return n;
   endfunction

   function automatic mst_t model_next(input int i, input mst_t s, input logic r,
                                       input logic v, input logic sof,
                                       input logic [31:0] d, output logic err);
      mst_t n;
      n   = s;
      err = 1'b0;
      n.ov = 1'b0;
      if (r) begin
         n.sync = (PSM[i] == 0);
         n.cnt  = '0;
         n.gap  = '0;
         n.out  = '0;
         n.ec   = '0;
         return n;
      end
      if (v) begin
         n.gap = '0;
         if (!n.sync) begin
            if (sof) begin
               n.sync = 1'b1;
               n = take(i, n, d);
            end
         end else if (PSM[i] != 0 && sof && n.cnt != 0) begin
            err   = 1'b1;
            n.cnt = '0;
            n = take(i, n, d);
         end else if (PSM[i] != 0 && !sof && n.cnt == 0) begin
            err    = 1'b1;
            n.sync = 1'b0;
         end else begin
            n = take(i, n, d);
         end
      end else if (PTO[i] > 0 && n.cnt != 0) begin
         if (int'(n.gap) == PTO[i] - 1) begin
            err   = 1'b1;
            n.cnt = '0;
            n.gap = '0;
            if (PSM[i] != 0) n.sync = 1'b0;
         end else begin
            n.gap = n.gap + 8'd1;
         end
      end
      if (err && int'(n.ec) < (1 << PCB[i]) - 1) n.ec = n.ec + 16'd1;
      return n;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Advance the reference model on every rising edge.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         logic e;
         m[i] <= model_next(i, m[i], rst, in_valid, in_sof, din, e);
      end
      started <= 1'b1;
   end

   // Compare all instances against the model midway through each cycle.
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 4; i++) begin
            logic e;
            void'(model_next(i, m[i], rst, in_valid, in_sof, din, e));
            check($sformatf("u%0d.out", i), dout[i], m[i].out);
            check($sformatf("u%0d.out_valid", i), 128'(ov[i]), 128'(m[i].ov));
            check($sformatf("u%0d.synced", i), 128'(sy[i]), 128'(m[i].sync));
            check($sformatf("u%0d.err_count", i), 128'(dec[i]), 128'(m[i].ec));
            check($sformatf("u%0d.frame_err", i), 128'(fe[i]), 128'(e));
         end
      end
   end

   task automatic cyc(input logic v, input logic s, input logic [31:0] d);
      in_valid = v;
      in_sof   = s;
      din      = d;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 32'h0);
      rst = 1'b0;
   endtask

   int len;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_sof = 1'b0;
      din = '0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      check("reset out", dout[0], 128'h0);
      check("reset out_valid", 128'(ov[0]), 128'h0);
      check("reset err_count", 128'(dec[0]), 128'h0);
      check("reset synced sof0", 128'(sy[0]), 128'h1);
      check("reset synced sof1", 128'(sy[1]), 128'h0);

      // Plain reassembly, no markers.
      cyc(1'b1, 1'b0, 32'h11111111);
      cyc(1'b1, 1'b0, 32'h22222222);
      check("basic frame1", dout[0], 128'h22222222_11111111);
      check("basic valid1", 128'(ov[0]), 128'h1);
      cyc(1'b1, 1'b0, 32'h33333333);
      check("basic no bubble", 128'(ov[0]), 128'h0);
      cyc(1'b1, 1'b0, 32'h44444444);
      check("basic frame2", dout[0], 128'h44444444_33333333);
      check("basic no err", 128'(dec[0]), 128'h0);

      // Alignment on the first marker.
      do_reset();
      cyc(1'b1, 1'b0, 32'hAAAA0001);
      check("align drop synced", 128'(sy[1]), 128'h0);
      check("align drop no err", 128'(dec[1]), 128'h0);
      cyc(1'b1, 1'b1, 32'h00000001);
      check("align synced", 128'(sy[1]), 128'h1);
      cyc(1'b1, 1'b0, 32'h00000002);
      check("align frame", dout[1], 128'h00000002_00000001);

      // Early marker restarts the frame.
      do_reset();
      cyc(1'b1, 1'b1, 32'h5);
      cyc(1'b1, 1'b1, 32'h6);
      cyc(1'b1, 1'b0, 32'h7);
      check("early sof count", 128'(dec[1]), 128'h1);
      check("early sof frame", dout[1], 128'h00000007_00000006);

      // Idle gaps: three tolerated, the fourth aborts.
      do_reset();
      cyc(1'b1, 1'b1, 32'h100);
      repeat (3) cyc(1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h101);
      check("gap frame", dout[1], 128'h00000101_00000100);
      cyc(1'b1, 1'b1, 32'h200);
      repeat (3) cyc(1'b0, 1'b0, 32'h0);
      #1;
      check("timeout frame_err", 128'(fe[1]), 128'h1);
      @(posedge clk);
      #2;
      check("timeout unsync", 128'(sy[1]), 128'h0);
      check("timeout count", 128'(dec[1]), 128'h1);
      check("timeout out held", dout[1], 128'h00000101_00000100);
      cyc(1'b1, 1'b1, 32'h300);
      cyc(1'b1, 1'b0, 32'h301);
      check("after timeout frame", dout[1], 128'h00000301_00000300);

      // Reset in the middle of a frame.
      do_reset();
      cyc(1'b1, 1'b0, 32'h9);
      do_reset();
      cyc(1'b1, 1'b0, 32'hA);
      cyc(1'b1, 1'b0, 32'hB);
      check("midreset frame", dout[0], 128'h0000000B_0000000A);
      check("midreset count", 128'(dec[0]), 128'h0);

      // Counter saturation with a 2-bit counter.
      do_reset();
      cyc(1'b1, 1'b1, 32'h1);
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 32'(k + 2));
      check("saturation", 128'(dec[1]), 128'h3);

      // Randomized traffic with idle bursts and occasional resets.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(299) == 0) begin
            do_reset();
         end else if ($urandom_range(19) == 0) begin
            len = $urandom_range(6, 2);
            for (int j = 0; j < len; j++) cyc(1'b0, 1'($urandom_range(1)), $urandom);
         end else begin
            cyc($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tdm_lane_deserializer.md
# tdm_lane_deserializer

Receive-side counterpart of the lane serializer. Takes a time-multiplexed stream of WIDTH-bit words (lane 0 first, one word per in_valid beat) and rebuilds the FACTOR-lane parallel word. It sits after per-sample processing in the fast clock domain, for example after the Tustin LPF, and before the per-channel I/Q consumers. Beyond plain reassembly, it adds frame alignment (optional start-of-frame marker), idle-gap timeout and error reporting, so a dropped or extra beat cannot silently swap channels.

## Interface
- FACTOR, 2, number of lanes per frame (≥1)
- WIDTH, 32, bits per lane word
- SOF_MODE, 0, 1 = align on in_sof; 0 = ignore in_sof, frames counted from reset
- TIMEOUT, 0, idle cycles tolerated mid-frame before abort; 0 = disabled
- CNT_BITS, 16, width of err_count

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in  in  WIDTH  serialized lane word
- in_valid  in  1  in carries a word this cycle
- in_sof  in  1  word is lane 0 of a frame (used only when SOF_MODE=1)
- out  out  FACTOR*WIDTH  reassembled frame; lane k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  one-cycle pulse: out updated this cycle
- frame_err  out  1  one-cycle pulse on any framing error or abort
- synced  out  1  1 when accepting frame data (state SYNCED)
- err_count  out  CNT_BITS  saturating count of frame_err pulses

## Operation
- State: UNSYNC / SYNCED. Lane index idx is 0..FACTOR-1. Gap counter gap. Shadow register holds lanes 0..FACTOR-2.
- Reset: state = SYNCED if SOF_MODE=0, else UNSYNC. idx=0, gap=0. out=0, out_valid=0, frame_err=0, err_count=0.
- SYNCED, in_valid, no error: word stored to lane idx, gap cleared.
  - If idx<FACTOR-1: idx++.
  - If idx==FACTOR-1: out ← {in, shadow lanes}, out_valid=1 next cycle, idx=0.
- SOF_MODE=1 errors:
  - in_sof with idx≠0: partial frame discarded, frame_err, and the word is taken as lane 0 (idx=1).
  - No in_sof with idx==0: frame_err, word discarded, go UNSYNC.
- UNSYNC: words without in_sof are discarded silently, with no error. A word with in_sof → SYNCED, stored as lane 0, idx=1.
- Timeout (TIMEOUT>0):
  - Each cycle with in_valid=0 and idx≠0 increments gap.
  - When in_valid=0, idx≠0 and gap==TIMEOUT-1: partial frame discarded, idx=0, gap=0, frame_err. Go UNSYNC if SOF_MODE=1; stay SYNCED if 0.
  - A valid beat always clears gap.
- FACTOR=1: every accepted word completes a frame. In SOF_MODE=1, in_sof is still required at idx=0.
- Partial frames never reach out. out holds its last complete frame until the next one completes.
- err_count increments on every frame_err pulse and saturates at all-ones.
- No backpressure: every valid beat is consumed the cycle it is presented.

## Timing
- Latency: out/out_valid are registered and appear 1 cycle after the beat carrying lane FACTOR-1.
- out_valid and frame_err are single-cycle pulses. Both may assert in the same cycle, e.g. a frame completes one cycle before an erroring beat is processed.
- Back-to-back frames at full rate give out_valid once every FACTOR cycles, with no bubble.
- synced is registered and reflects the state after the current edge.
- rst asserted mid-frame: the partial frame is dropped. Outputs return to reset values on the next edge, and err_count is cleared.
- in_valid=0 cycles never change out. They change idx only through timeout.

## Test plan
- Basic reassembly, FACTOR=2, SOF_MODE=0: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back → out=0x22222222_11111111 one cycle after beat 2, then 0x44444444_33333333. out_valid pulses are 2 cycles apart; frame_err never asserts.
- Alignment, SOF_MODE=1: after reset send 0xAAAA0001 (no sof), then 0x00000001 (sof), 0x00000002 → first word dropped with no frame_err. out=0x00000002_00000001. synced goes 1 after the sof beat.
- Early sof: sof 0x5, then sof 0x6, then 0x7 → frame_err once, err_count=1, out=0x00000007_00000006. The 0x5 word never appears on out.
- Gaps and timeout, TIMEOUT=4: send lane 0, idle 3 cycles, lane 1 → normal frame. Send lane 0, idle 4 cycles → frame_err on the 4th idle cycle. The next sof word starts a new frame, and out is unchanged until then.
- Reset mid-frame: lane 0 = 0x9, assert rst 1 cycle, then 0xA, 0xB (SOF_MODE=0) → out=0x0000000B_0000000A. 0x9 is discarded and err_count=0.
- Saturation, CNT_BITS=2: 5 early-sof errors → err_count sticks at 3.
